// File: rtl/etroc2_tag_pkg.sv
`default_nettype none
// ============================================================================
// Module      : etroc2_tag_pkg
// Description : Shared defaults and types for the ETROC2 tag capture path.
// Revision    : 1.0 - initial release
// ============================================================================
package etroc2_tag_pkg;

    localparam int C_BCID_W   = 12;
    localparam int C_BCID_MAX = 3563;
    localparam int C_CNT_W    = 8;

    typedef logic [C_BCID_W-1:0] bcid_t;

endpackage : etroc2_tag_pkg
`default_nettype wire

// File: rtl/tag_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : tag_sync_edge
// Description : Two-flop synchroniser for the asynchronous latched tag level
//               followed by rising-edge detection. With the build macro
//               TAG_CAPTURE_GLITCH_FILTER_EN defined, an extra delay stage
//               requires two consecutive high samples before reporting a rise.
// Revision    : 1.0 - initial release
// ============================================================================
module tag_sync_edge (
    input  logic clk,
    input  logic rstn,
    input  logic i_tag,
    output logic o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_s3;

    // Metastability chain (s1 -> s2, nothing in between) plus edge-history flop
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
            r_s3 <= 1'b0;
        end else begin
            r_s1 <= i_tag;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

`ifdef TAG_CAPTURE_GLITCH_FILTER_EN
    logic r_s4;

    // Second history flop so a rise needs two high synchronised samples
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s4 <= 1'b0;
        end else begin
            r_s4 <= r_s3;
        end
    end

    assign o_rise = r_s2 & r_s3 & ~r_s4;
`else
    assign o_rise = r_s2 & ~r_s3;
`endif

endmodule : tag_sync_edge
`default_nettype wire

// File: rtl/tag_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tag_capture_fifo
// Description : Synchronises the latched tag level, timestamps each new tag
//               with the local BCID and queues the timestamp in a small FIFO
//               drained through a valid/ready handshake. Tracks dropped tags.
//               Build macro: TAG_CAPTURE_GLITCH_FILTER_EN (see tag_sync_edge).
// Revision    : 1.0 - initial release
// ============================================================================
module tag_capture_fifo
    import etroc2_tag_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int BCID_W   = C_BCID_W,
    parameter int BCID_MAX = C_BCID_MAX,
    parameter int CNT_W    = C_CNT_W
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       tag_in,
    input  logic                       bc0,
    input  logic [BCID_W-1:0]          bcid_offset,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BCID_W-1:0]          out_bcid,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic                       overflow,
    output logic [CNT_W-1:0]           drop_cnt,
    input  logic                       clr_status
);

    localparam int                AW     = $clog2(DEPTH);
    localparam int                LW     = AW + 1;
    localparam logic [LW-1:0]     C_FULL = LW'(DEPTH);
    localparam logic [BCID_W-1:0] C_BMAX = BCID_W'(BCID_MAX);

    logic [BCID_W-1:0] r_bcid;
    logic [BCID_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    logic [BCID_W-1:0] r_out_bcid;
    logic              r_overflow;
    logic [CNT_W-1:0]  r_drop_cnt;

    logic              w_rise;
    logic              w_full;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [AW-1:0]     w_rd_next;

    tag_sync_edge u_sync (
        .clk    (clk),
        .rstn   (rstn),
        .i_tag  (tag_in),
        .o_rise (w_rise)
    );

    // A full FIFO still accepts a push when the head leaves in the same cycle
    assign w_full    = (r_level == C_FULL);
    assign w_pop     = out_valid & out_ready;
    assign w_push    = w_rise & (~w_full | w_pop);
    assign w_drop    = w_rise & w_full & ~w_pop;
    assign w_rd_next = r_rd_ptr + 1'b1;

    // Free-running bunch-crossing counter; bc0 reload beats increment and wrap
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bcid <= '0;
        end else if (bc0) begin
            r_bcid <= bcid_offset;
        end else if (r_bcid == C_BMAX) begin
            r_bcid <= '0;
        end else begin
            r_bcid <= r_bcid + 1'b1;
        end
    end

    // Timestamp storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= r_bcid;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_next;
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + LW'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - LW'(1);
            end
        end
    end

    // Registered head: refreshed on a pop, or when a write lands in an empty FIFO
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_out_bcid <= '0;
        end else if (w_pop) begin
            if (r_level > LW'(1)) begin
                r_out_bcid <= r_mem[w_rd_next];
            end else if (w_push) begin
                r_out_bcid <= r_bcid;
            end
        end else if (w_push && (r_level == '0)) begin
            r_out_bcid <= r_bcid;
        end
    end

    // Sticky overflow and saturating drop counter; a drop outranks a clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (clr_status) begin
                r_drop_cnt <= CNT_W'(1);
            end else if (r_drop_cnt != '1) begin
                r_drop_cnt <= r_drop_cnt + 1'b1;
            end
        end else if (clr_status) begin
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end
    end

    assign out_valid  = (r_level != '0);
    assign out_bcid   = r_out_bcid;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;
    assign drop_cnt   = r_drop_cnt;

endmodule : tag_capture_fifo
`default_nettype wire

// File: tb/tb_tag_capture_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_tag_capture_fifo
// Description : Directed self-checking bench for tag_capture_fifo.
//               Honours build macro TAG_CAPTURE_GLITCH_FILTER_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tag_capture_fifo;
    import etroc2_tag_pkg::*;

`ifdef TAG_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT        = 4;
    localparam int GLITCH_LVL = 0;
`else
    localparam int LAT        = 3;
    localparam int GLITCH_LVL = 1;
`endif

    logic        clk;
    logic        rstn;
    logic        tag_in;
    logic        bc0;
    bcid_t       bcid_offset;
    logic        out_valid;
    logic        out_ready;
    bcid_t       out_bcid;
    logic [3:0]  fifo_level;
    logic        overflow;
    logic [7:0]  drop_cnt;
    logic        clr_status;

    int vectors    = 0;
    int miscompares = 0;

    tag_capture_fifo dut (
        .clk         (clk),
        .rstn        (rstn),
        .tag_in      (tag_in),
        .bc0         (bc0),
        .bcid_offset (bcid_offset),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bcid    (out_bcid),
        .fifo_level  (fifo_level),
        .overflow    (overflow),
        .drop_cnt    (drop_cnt),
        .clr_status  (clr_status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_bc0(input int off);
        bcid_offset = bcid_t'(off);
        bc0 = 1'b1;
        tick();
        bc0 = 1'b0;
    endtask

    // Two-cycle tag followed by three idle cycles; the entry lands within the window
    task automatic send_tag;
        tag_in = 1'b1;
        tick();
        tick();
        tag_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset;
        #2;
        vectors++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0 ||
            drop_cnt !== 8'd0 || out_bcid !== 12'd0) begin
            miscompares++;
            $display("FAIL reset_values: valid=%b level=%0d ovf=%b drop=%0d bcid=%0d, want all 0",
                     out_valid, fifo_level, overflow, drop_cnt, out_bcid);
        end
        tick();
        tick();
        rstn = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_release: valid=%b level=%0d, want 0 0", out_valid, fifo_level);
        end
    endtask

    task automatic test_single;
        out_ready = 1'b1;
        do_bc0(100);
        tag_in = 1'b1;
        tick();
        tick();
        tag_in = 1'b0;
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_early: valid=%b, want 0", out_valid);
        end
        repeat (LAT - 3) tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_pre: valid=%b, want 0", out_valid);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_bcid !== bcid_t'(100 + LAT - 1) || fifo_level !== 4'd1) begin
            miscompares++;
            $display("FAIL single_entry: valid=%b bcid=%0d level=%0d, want 1 %0d 1",
                     out_valid, out_bcid, fifo_level, 100 + LAT - 1);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL single_pop: valid=%b level=%0d, want 0 0", out_valid, fifo_level);
        end
        out_ready = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_wrap;
        bcid_t exp;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            do_bc0(3562 + i - (LAT - 1));
            send_tag();
        end
        vectors++;
        if (fifo_level !== 4'd3) begin
            miscompares++;
            $display("FAIL wrap_level: level=%0d, want 3", fifo_level);
        end
        for (int i = 0; i < 3; i++) begin
            exp = (i == 2) ? bcid_t'(0) : bcid_t'(3562 + i);
            vectors++;
            if (out_valid !== 1'b1 || out_bcid !== exp) begin
                miscompares++;
                $display("FAIL wrap_seq%0d: valid=%b bcid=%0d, want 1 %0d", i, out_valid, out_bcid, exp);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        vectors++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL wrap_empty: valid=%b level=%0d, want 0 0", out_valid, fifo_level);
        end
    endtask

    task automatic test_overflow;
        out_ready = 1'b0;
        do_bc0(0);
        for (int i = 0; i < 10; i++) send_tag();
        vectors++;
        if (fifo_level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2) begin
            miscompares++;
            $display("FAIL ovf_state: level=%0d ovf=%b drop=%0d, want 8 1 2", fifo_level, overflow, drop_cnt);
        end
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        vectors++;
        if (overflow !== 1'b0 || drop_cnt !== 8'd0 || fifo_level !== 4'd8) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf=%b drop=%0d level=%0d, want 0 0 8", overflow, drop_cnt, fifo_level);
        end
        // drop lands on the same edge as the clear
        tag_in = 1'b1;
        tick();
        tick();
        tag_in = 1'b0;
        repeat (LAT - 3) tick();
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        vectors++;
        if (overflow !== 1'b1 || drop_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL drop_beats_clr: ovf=%b drop=%0d, want 1 1", overflow, drop_cnt);
        end
        repeat (3) tick();
        for (int i = 0; i < 260; i++) send_tag();
        vectors++;
        if (drop_cnt !== 8'd255 || fifo_level !== 4'd8) begin
            miscompares++;
            $display("FAIL drop_saturate: drop=%0d level=%0d, want 255 8", drop_cnt, fifo_level);
        end
    endtask

    task automatic test_full_push_pop;
        bcid_t exp;
        do_bc0(1000);
        tag_in = 1'b1;
        tick();
        tick();
        tag_in = 1'b0;
        repeat (LAT - 3) tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (fifo_level !== 4'd8 || drop_cnt !== 8'd255 || out_bcid !== bcid_t'(LAT - 1 + 5)) begin
            miscompares++;
            $display("FAIL full_pushpop: level=%0d drop=%0d bcid=%0d, want 8 255 %0d",
                     fifo_level, drop_cnt, out_bcid, LAT - 1 + 5);
        end
        repeat (3) tick();
        for (int i = 1; i <= 8; i++) begin
            exp = (i == 8) ? bcid_t'(1000 + LAT - 1) : bcid_t'(LAT - 1 + 5 * i);
            vectors++;
            if (out_valid !== 1'b1 || out_bcid !== exp) begin
                miscompares++;
                $display("FAIL order%0d: valid=%b bcid=%0d, want 1 %0d", i, out_valid, out_bcid, exp);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
        vectors++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL drain_empty: valid=%b level=%0d, want 0 0", out_valid, fifo_level);
        end
    endtask

    task automatic test_long;
        out_ready = 1'b0;
        tag_in = 1'b1;
        repeat (50) tick();
        tag_in = 1'b0;
        repeat (6) tick();
        vectors++;
        if (fifo_level !== 4'd1) begin
            miscompares++;
            $display("FAIL long_tag: level=%0d, want 1", fifo_level);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_glitch;
        tag_in = 1'b1;
        tick();
        tag_in = 1'b0;
        repeat (6) tick();
        vectors++;
        if (fifo_level !== 4'(GLITCH_LVL)) begin
            miscompares++;
            $display("FAIL glitch_pulse: level=%0d, want %0d", fifo_level, GLITCH_LVL);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        vectors++;
        if (fifo_level !== 4'd0) begin
            miscompares++;
            $display("FAIL glitch_drain: level=%0d, want 0", fifo_level);
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) send_tag();
        vectors++;
        if (fifo_level !== 4'd3 || overflow !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_queued: level=%0d ovf=%b, want 3 1", fifo_level, overflow);
        end
        rstn = 1'b0;
        #2;
        vectors++;
        if (out_valid !== 1'b0 || fifo_level !== 4'd0 || overflow !== 1'b0 || drop_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL mid_reset: valid=%b level=%0d ovf=%b drop=%0d, want 0 0 0 0",
                     out_valid, fifo_level, overflow, drop_cnt);
        end
        tick();
        rstn = 1'b1;
        tag_in = 1'b1;
        tick();
        tick();
        tag_in = 1'b0;
        repeat (4) tick();
        vectors++;
        if (fifo_level !== 4'd1 || out_bcid !== bcid_t'(LAT - 1)) begin
            miscompares++;
            $display("FAIL mid_restart: level=%0d bcid=%0d, want 1 %0d", fifo_level, out_bcid, LAT - 1);
        end
    endtask

    initial begin
        rstn        = 1'b0;
        tag_in      = 1'b0;
        bc0         = 1'b0;
        bcid_offset = '0;
        out_ready   = 1'b0;
        clr_status  = 1'b0;
        test_reset();
        test_single();
        test_wrap();
        test_overflow();
        test_full_push_pop();
        test_long();
        test_glitch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_tag_capture_fifo
`default_nettype wire
